lms_spi_responder: RTL and testbench
====================================

Name: lms_spi_responder

Overview:
- Synthesizable SPI slave modelling the LMS6002D serial control port: the responder end of the 16-bit SEN/SCLK/MOSI/MISO transactions issued by the core SPI master.
- Holds a 128 x 8 register file, oversamples the SPI pins in a single fast clock domain, and commits writes, serves reads and exposes a local register port.
- Used as the LMS stand-in for loopback builds and as a bench model for the SPI routing logic.

Parameters:
- CHIP_ID, 8'h22, read-only value at address 7'h04; SPI and local writes to 7'h04 are ignored.
- MIN_HALF, 4, minimum SCLK high/low time in clk cycles that the block guarantees to follow.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sen  in  1  SPI enable, active low, async to clk.
- sclk  in  1  SPI clock, async to clk.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- miso_oe  out  1  high while miso is driven (read data phase).
- loc_addr  in  7  local port address.
- loc_rdata  out  8  regs[loc_addr], combinational read.
- loc_we  in  1  local write strobe.
- loc_wdata  in  8  local write data.
- wr_stb  out  1  one-cycle pulse on every committed SPI write.
- wr_addr  out  7  address of the last SPI write; held until the next one.
- wr_data  out  8  data of the last SPI write; held until the next one.

Behaviour:
- Interface is fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - miso=0, miso_oe=0, wr_stb=0, wr_addr=0, wr_data=0.
  - All registers 0, except 7'h04 which reads CHIP_ID.
  - FSM in IDLE.
- Synchronisation:
  - sen, sclk and mosi each pass through a 2-FF synchroniser, followed by a third stage for edge detection.
  - Pin-to-event latency is 3 clk.
- Frame format, MSB first, 16 bits:
  - bit15: 1 = write, 0 = read.
  - bits14:8: address.
  - bits7:0: data.
- Data is sampled on sclk rising edges; miso changes on sclk falling edges.
- FSM states: IDLE, CMD, WDATA, RDATA, DONE.
  - IDLE -> CMD on sen falling; bit counter cleared.
  - CMD: shift mosi on each rising edge. After the 8th rising edge, decode and go to WDATA if bit15=1, RDATA if bit15=0.
  - RDATA:
    - On decode, latch shadow = regs[addr].
    - On the next falling edge, set miso_oe=1 and miso=shadow[7].
    - Each following falling edge shifts out the next bit.
    - After the 16th rising edge, go to DONE.
  - WDATA: shift 8 bits. On the 16th rising edge, commit regs[addr] and pulse wr_stb the cycle after commit. wr_addr/wr_data update together with the commit. Then go to DONE.
  - DONE: extra sclk edges are ignored; miso holds its last value.
  - Any state -> IDLE on sen rising.
- Abort: sen rising before 16 rising edges means no commit and no wr_stb; miso_oe=0 and miso=0 on the same cycle the sen rise is detected.
- sen rising always clears miso_oe and miso.
- Address 7'h04: commit is suppressed, but wr_stb still pulses with the attempted data.
- Simultaneous SPI commit and loc_we to the same address: the SPI value wins. Different addresses: both commit.
- A read's shadow is latched at decode, so a local write during the data phase does not alter bits already being shifted out.
- Reset mid-frame: immediate return to reset values; the frame is discarded.
- sclk half-periods shorter than MIN_HALF clk cycles are unsupported; behaviour is undefined.

Optional Feature:
- LMS_SPI_ERR_CNT_EN:
  - Adds output err_cnt [7:0], reset 0, and input err_clr.
  - Increments on each aborted frame; saturates at 8'hFF.
  - err_clr synchronously zeroes it; err_clr wins over a same-cycle increment.
- Without the macro: no err_cnt/err_clr ports; aborts are silent.

Test Plan:
- Write 16'h8A5C (addr 7'h0A, data 8'h5C), sclk = clk/10 -> wr_stb exactly one pulse, wr_addr=7'h0A, wr_data=8'h5C, loc_rdata at 7'h0A = 8'h5C.
- Read 16'h0A00 after the above -> miso shifts 0,1,0,1,1,1,0,0 on successive falling edges; miso_oe high only in the data phase.
- Read 7'h04 after SPI write 16'h84FF -> returns 8'h22; wr_stb pulses, register unchanged.
- sen deasserted after 11 bits of 16'h8B33 -> regs[7'h0B] unchanged, no wr_stb, miso_oe=0; err_cnt=1 when LMS_SPI_ERR_CNT_EN is defined.
- loc_we to 7'h10 with 8'h11 in the same cycle as SPI commit of 8'h77 to 7'h10 -> final value 8'h77.
- rst_n asserted mid-read of 7'h0A -> miso_oe=0 and miso=0 immediately, all registers 0, next frame decodes normally.

Source files
------------

// File: rtl/lms_spi_responder.sv
// LMS6002D-style SPI register responder (128 x 8 regs); optional abort counter via LMS_SPI_ERR_CNT_EN.
// Latency: 3 clk from SPI pin edge to register commit / miso update.
// Backpressure: none; sclk half-periods must be at least MIN_HALF clk cycles.
module lms_spi_responder #(
    parameter logic [7:0]  CHIP_ID  = 8'h22,
    parameter int unsigned MIN_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sen,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [6:0] loc_addr,
    output logic [7:0] loc_rdata,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
`ifdef LMS_SPI_ERR_CNT_EN
    input  logic       err_clr,
    output logic [7:0] err_cnt,
`endif
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam logic [6:0] ID_ADDR = 7'h04;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sen_sr, sclk_sr, mosi_sr;
    logic        sen_rise, sen_fall, sclk_rise, sclk_fall, mosi_bit;
    logic [4:0]  bit_cnt;
    logic [6:0]  shift_q;
    logic [7:0]  byte_now;
    logic [6:0]  addr_q;
    logic [7:0]  shadow_q;
    logic [7:0]  dec_rdata;
    logic        in_frame, last_rise, decode, commit, abort;
    logic [7:0]  regs [128];

    assign sen_rise  =  sen_sr[1]  & ~sen_sr[2];
    assign sen_fall  = ~sen_sr[1]  &  sen_sr[2];
    assign sclk_rise =  sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] &  sclk_sr[2];
    // With long enough half-periods the one-cycle-older mosi sample is safely settled.
    assign mosi_bit  = (MIN_HALF > 1) ? mosi_sr[2] : mosi_sr[1];

    assign byte_now  = {shift_q, mosi_bit};
    assign in_frame  = (state_q == CMD) || (state_q == WDATA) || (state_q == RDATA);
    assign last_rise = sclk_rise && (bit_cnt == 5'd15);
    assign decode    = (state_q == CMD) && sclk_rise && (bit_cnt == 5'd7) && !sen_rise;
    assign commit    = (state_q == WDATA) && last_rise && !sen_rise;
    assign abort     = sen_rise && in_frame;

    assign loc_rdata = (loc_addr == ID_ADDR) ? CHIP_ID : regs[loc_addr];
    assign dec_rdata = (byte_now[6:0] == ID_ADDR) ? CHIP_ID : regs[byte_now[6:0]];

    always_comb begin
        state_d = state_q;
        if (sen_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sen_fall) state_d = CMD;
                CMD:     if (decode) state_d = byte_now[7] ? WDATA : RDATA;
                WDATA,
                RDATA:   if (last_rise) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sen_sr  <= 3'b111;
            sclk_sr <= 3'b000;
            mosi_sr <= 3'b000;
        end else begin
            state_q <= state_d;
            sen_sr  <= {sen_sr[1:0], sen};
            sclk_sr <= {sclk_sr[1:0], sclk};
            mosi_sr <= {mosi_sr[1:0], mosi};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            shadow_q <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_stb <= commit;
            if (state_q == IDLE && sen_fall) begin
                bit_cnt <= '0;
            end else if (in_frame && sclk_rise) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_rise && (state_q == CMD || state_q == WDATA)) begin
                shift_q <= byte_now[6:0];
            end
            if (decode) begin
                addr_q   <= byte_now[6:0];
                shadow_q <= dec_rdata;
            end
            if (sen_rise) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else if (state_q == RDATA && sclk_fall) begin
                miso_oe  <= 1'b1;
                miso     <= shadow_q[7];
                shadow_q <= {shadow_q[6:0], 1'b0};
            end
            if (commit) begin
                wr_addr <= addr_q;
                wr_data <= byte_now;
            end
        end
    end

    // SPI write is assigned last so it wins a same-address collision with the local port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) regs[i] <= '0;
        end else begin
            if (loc_we && loc_addr != ID_ADDR) regs[loc_addr] <= loc_wdata;
            if (commit && addr_q != ID_ADDR) regs[addr_q] <= byte_now;
        end
    end

`ifdef LMS_SPI_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (abort && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_lms_spi_responder.sv
// Directed bench for lms_spi_responder with read/write scoreboards.
module tb_lms_spi_responder;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n, sen, sclk, mosi;
    logic       miso, miso_oe;
    logic [6:0] loc_addr;
    logic [7:0] loc_rdata;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
`ifdef LMS_SPI_ERR_CNT_EN
    logic       err_clr;
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    logic        rd_q [$];
    logic [14:0] wr_q [$];
    logic [7:0]  mdl [128];

    lms_spi_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sen       (sen),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
`ifdef LMS_SPI_ERR_CNT_EN
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
`endif
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_stb === 1'b1) begin
            stb_cnt++;
            checks++;
            assert (wr_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_stb_unexpected: got addr %0h data %0h expected no pulse", wr_addr, wr_data);
            end
            if (wr_q.size() != 0) chk("wr_addr_data", {wr_addr, wr_data}, {17'd0, wr_q.pop_front()});
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        mdl[4] = 8'h22;
        rd_q.delete();
    endtask

    task automatic loc_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        loc_addr = a;
        #1;
        chk(tag, loc_rdata, exp);
    endtask

    task automatic spi_frame(input logic [15:0] f, input int nbits, input bit collide, input bit keep_sen);
        logic [6:0] a;
        logic [7:0] d;
        logic       bit_exp;
        a = f[14:8];
        d = f[7:0];
        if (!f[15]) begin
            for (int k = 7; k >= 0; k--) rd_q.push_back(mdl[a][k]);
        end else if (nbits == 16) begin
            wr_q.push_back({a, d});
            if (a != 7'h04) mdl[a] = d;
        end
        sen = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            mosi = f[15 - b];
            repeat (HALF) @(negedge clk);
            if (!f[15] && b >= 8) begin
                chk("miso_oe_data", miso_oe, 1);
                checks++;
                assert (rd_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rd_q_empty: got miso %0b expected queued bit", miso);
                end
                if (rd_q.size() != 0) begin
                    bit_exp = rd_q.pop_front();
                    chk("miso_bit", miso, bit_exp);
                end
            end else begin
                chk("miso_oe_idle", miso_oe, 0);
            end
            sclk = 1'b1;
            if (collide && b == 15) begin
                @(negedge clk);
                @(negedge clk);
                loc_addr = a; loc_wdata = 8'h11; loc_we = 1'b1;
                @(negedge clk);
                loc_we = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (keep_sen) return;
        repeat (HALF) @(negedge clk);
        if (!f[15] && nbits == 16) chk("miso_oe_done", miso_oe, 1);
        sen = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("miso_oe_after", miso_oe, 0);
        chk("miso_after", miso, 0);
    endtask

    initial begin
        int stb0;
        rst_n = 1'b0; sen = 1'b1; sclk = 1'b0; mosi = 1'b0;
        loc_addr = '0; loc_we = 1'b0; loc_wdata = '0;
`ifdef LMS_SPI_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        loc_chk("rst_reg0a", 7'h0A, 8'h00);
        loc_chk("rst_chip_id", 7'h04, 8'h22);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        stb0 = stb_cnt;
        spi_frame(16'h8A5C, 16, 0, 0);
        chk("wr1_pulses", stb_cnt - stb0, 1);
        chk("wr1_addr", wr_addr, 7'h0A);
        chk("wr1_data", wr_data, 8'h5C);
        loc_chk("wr1_loc", 7'h0A, 8'h5C);

        spi_frame(16'h0A00, 16, 0, 0);

        stb0 = stb_cnt;
        spi_frame(16'h84FF, 16, 0, 0);
        chk("id_wr_pulses", stb_cnt - stb0, 1);
        chk("id_wr_data", wr_data, 8'hFF);
        loc_chk("id_unchanged", 7'h04, 8'h22);
        spi_frame(16'h0400, 16, 0, 0);

        stb0 = stb_cnt;
        spi_frame(16'h8B33, 11, 0, 0);
        chk("abort_pulses", stb_cnt - stb0, 0);
        loc_chk("abort_reg0b", 7'h0B, 8'h00);
`ifdef LMS_SPI_ERR_CNT_EN
        chk("err_cnt_abort", err_cnt, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cnt_clr", err_cnt, 0);
`endif

        stb0 = stb_cnt;
        spi_frame(16'h9077, 16, 1, 0);
        mdl[7'h10] = 8'h77;
        chk("collide_pulses", stb_cnt - stb0, 1);
        loc_chk("collide_reg10", 7'h10, 8'h77);
        spi_frame(16'h1000, 16, 0, 0);

        loc_addr = 7'h20; loc_wdata = 8'h99; loc_we = 1'b1;
        @(negedge clk);
        loc_addr = 7'h04; loc_wdata = 8'h55;
        @(negedge clk);
        loc_we = 1'b0;
        mdl[7'h20] = 8'h99;
        loc_chk("loc_wr20", 7'h20, 8'h99);
        loc_chk("loc_wr_id", 7'h04, 8'h22);

        spi_frame(16'h0A00, 12, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_miso_oe", miso_oe, 0);
        chk("midrst_miso", miso, 0);
        loc_chk("midrst_reg0a", 7'h0A, 8'h00);
        loc_chk("midrst_reg10", 7'h10, 8'h00);
        reset_model();
        sen = 1'b1; sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_frame(16'h0400, 16, 0, 0);
        spi_frame(16'h8B33, 16, 0, 0);
        loc_chk("post_rst_reg0b", 7'h0B, 8'h33);
        spi_frame(16'h0B00, 16, 0, 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
